mem_port_arbiter: RTL

//   Shares the single external memory refill port between two cacheController

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory refill port between the
// instruction cache (requester 0) and the data cache (requester 1).
// Round-robin grant, held for a full BEATS-word refill burst, followed by a
// single release cycle before the next arbitration.
module mem_port_arbiter #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cc2arb_0,
  input  logic [ADR_WIDTH-1:0]  adr_cc2arb_0,
  output logic                  ack_arb2cc_0,
  output logic [DATA_WIDTH-1:0] dat_arb2cc_0,
  input  logic                  req_cc2arb_1,
  input  logic [ADR_WIDTH-1:0]  adr_cc2arb_1,
  output logic                  ack_arb2cc_1,
  output logic [DATA_WIDTH-1:0] dat_arb2cc_1,
  output logic                  req_arb2mem,
  output logic [ADR_WIDTH-1:0]  adr_arb2mem,
  input  logic                  ack_mem2arb,
  input  logic [DATA_WIDTH-1:0] dat_mem2arb,
  output logic                  busy,
  output logic                  owner,
  output logic                  err_spurious
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state_reg,    state_next;
  logic                 rr_ptr_reg,   rr_ptr_next;
  logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;
  logic                 owner_reg,    owner_next;
  logic [ADR_WIDTH-1:0] adr_reg,      adr_next;
  logic                 req_mem_reg,  req_mem_next;
  logic                 err_reg,      err_next;

  // Requester-indexed views so arbitration and routing can be written once.
  logic [1:0]            req_vec;
  logic [ADR_WIDTH-1:0]  adr_vec [2];
  logic [1:0]            ack_vec;
  logic [DATA_WIDTH-1:0] dat_vec [2];
  logic                  winner;

  assign req_vec    = {req_cc2arb_1, req_cc2arb_0};
  assign adr_vec[0] = adr_cc2arb_0;
  assign adr_vec[1] = adr_cc2arb_1;

  // The pointer side wins when it is asking; otherwise the other side must be.
  assign winner = req_vec[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;

  // Beats are steered to the owner only while a burst is in flight; stray
  // memory acks outside BUSY never reach either cache.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_route
      logic sel;
      assign sel         = (state_reg == ST_BUSY) && (owner_reg == 1'(gi));
      assign ack_vec[gi] = sel & ack_mem2arb;
      assign dat_vec[gi] = sel ? dat_mem2arb : '0;
    end
  endgenerate

  assign ack_arb2cc_0 = ack_vec[0];
  assign ack_arb2cc_1 = ack_vec[1];
  assign dat_arb2cc_0 = dat_vec[0];
  assign dat_arb2cc_1 = dat_vec[1];

  assign req_arb2mem  = req_mem_reg;
  assign adr_arb2mem  = adr_reg;
  assign busy         = (state_reg == ST_BUSY);
  assign owner        = owner_reg;
  assign err_spurious = err_reg;

  // Next-state logic: grant in IDLE, count beats in BUSY, one idle cycle in RELEASE.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    owner_next    = owner_reg;
    adr_next      = adr_reg;
    req_mem_next  = req_mem_reg;
    err_next      = err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (|req_vec) begin
          owner_next    = winner;
          adr_next      = adr_vec[winner];
          req_mem_next  = 1'b1;
          beat_cnt_next = '0;
          state_next    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Memory cannot abort, so the burst runs to BEATS acks even if the
        // owner has already dropped its request.
        if (ack_mem2arb) begin
          if (beat_cnt_reg == LAST_BEAT) begin
            req_mem_next = 1'b0;
            rr_ptr_next  = ~owner_reg;
            state_next   = ST_RELEASE;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next   = ST_IDLE;
        req_mem_next = 1'b0;
      end
    endcase

    // A memory ack with no burst outstanding is a protocol error; latch it.
    if (ack_mem2arb && (state_reg != ST_BUSY)) begin
      err_next = 1'b1;
    end
  end

  // State register; reset drops any in-flight burst immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= 1'b0;
      beat_cnt_reg <= '0;
      owner_reg    <= 1'b0;
      adr_reg      <= '0;
      req_mem_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      owner_reg    <= owner_next;
      adr_reg      <= adr_next;
      req_mem_reg  <= req_mem_next;
      err_reg      <= err_next;
    end
  end

endmodule
